// File: rtl/fp_pkg.sv
// Shared widths, constants and the S1->S2 payload for the FP multiply back end.
package fp_pkg;

    localparam int FP_WIDTH   = 32;
    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int BIAS       = 127;
    localparam int SEXP_W     = EXP_WIDTH + 2;          // signed exponent carried through the pipe
    localparam int PROD_W     = 2 * (MANT_WIDTH + 1);   // hidden-bit mantissa product

    localparam logic [FP_WIDTH-1:0] QNAN = 32'h7FC00000;

    // Normalised operand waiting to be rounded.
    typedef struct packed {
        logic                     sign;
        logic signed [SEXP_W-1:0] exp;
        logic [MANT_WIDTH:0]      mant;    // includes hidden bit
        logic                     guard;
        logic                     sticky;
        logic                     is_nan;
        logic                     is_inf;
        logic                     is_zero;
    } norm_t;

    // Align the product so the leading one sits in mant[MANT_WIDTH]; a product
    // in [2,4) shifts right by one and bumps the exponent.
    function automatic norm_t normalize(input logic              sign,
                                        input logic [SEXP_W-1:0] exp,
                                        input logic [PROD_W-1:0] prod,
                                        input logic              is_nan,
                                        input logic              is_inf,
                                        input logic              is_zero);
        norm_t n;
        n.sign    = sign;
        n.is_nan  = is_nan;
        n.is_inf  = is_inf;
        n.is_zero = is_zero;
        if (prod[PROD_W-1]) begin
            n.mant   = prod[PROD_W-1 -: MANT_WIDTH+1];
            n.guard  = prod[MANT_WIDTH];
            n.sticky = |prod[MANT_WIDTH-1:0];
            n.exp    = exp + SEXP_W'(1);
        end else begin
            n.mant   = prod[PROD_W-2 -: MANT_WIDTH+1];
            n.guard  = prod[MANT_WIDTH-1];
            n.sticky = |prod[MANT_WIDTH-2:0];
            n.exp    = exp;
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, range check and IEEE packing of a normalised operand.
module fp_round_pack
    import fp_pkg::*;
(
    input  norm_t               s,
    output logic [FP_WIDTH-1:0] result,
    output logic [2:0]          flags    // {overflow, underflow, inexact}
);

    localparam logic signed [SEXP_W-1:0] EXP_MAX  = SEXP_W'((2 ** EXP_WIDTH) - 1);
    localparam logic signed [SEXP_W-1:0] EXP_ZERO = '0;

    logic                     round_up;
    logic [MANT_WIDTH+1:0]    sum;
    logic [MANT_WIDTH:0]      mant_r;
    logic signed [SEXP_W-1:0] exp_r;
    logic                     inexact;
    logic                     lost_any;

    assign round_up = s.guard & (s.sticky | s.mant[0]);
    assign sum      = {1'b0, s.mant} + {{(MANT_WIDTH+1){1'b0}}, round_up};
    // Carry out of the mantissa means it rolled to 2.0: restart at 1.0, exp+1.
    assign mant_r   = sum[MANT_WIDTH+1] ? {1'b1, {MANT_WIDTH{1'b0}}} : sum[MANT_WIDTH:0];
    assign exp_r    = sum[MANT_WIDTH+1] ? s.exp + SEXP_W'(1) : s.exp;
    assign inexact  = s.guard | s.sticky;
    // Flushing to zero throws the whole significand away.
    assign lost_any = (|s.mant) | s.guard | s.sticky;

    // Specials first, then range checks on the rounded exponent, then normal pack.
    always_comb begin
        result = '0;
        flags  = '0;
        if (s.is_nan) begin
            result = QNAN;
        end else if (s.is_inf) begin
            result = {s.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else if (s.is_zero) begin
            result = {s.sign, {(FP_WIDTH-1){1'b0}}};
        end else if (exp_r >= EXP_MAX) begin
            result = {s.sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            flags  = 3'b101;
        end else if (exp_r <= EXP_ZERO) begin
            result = {s.sign, {(FP_WIDTH-1){1'b0}}};
            flags  = {2'b01, lost_any};
        end else begin
            result = {s.sign, exp_r[EXP_WIDTH-1:0], mant_r[MANT_WIDTH-1:0]};
            flags  = {2'b00, inexact};
        end
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// FP multiply back end: S1 normalises the mantissa product, S2 rounds and packs.
module fp_mul_norm_round #(
    parameter int FP_WIDTH   = fp_pkg::FP_WIDTH,
    parameter int EXP_WIDTH  = fp_pkg::EXP_WIDTH,
    parameter int MANT_WIDTH = fp_pkg::MANT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sign,
    input  logic [EXP_WIDTH+1:0]        in_exp,
    input  logic [2*(MANT_WIDTH+1)-1:0] in_prod,
    input  logic                        in_is_nan,
    input  logic                        in_is_inf,
    input  logic                        in_is_zero,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FP_WIDTH-1:0]         out_result,
    output logic [2:0]                  out_flags
);

    fp_pkg::norm_t       s1_q;
    logic                s1_valid;
    logic                s2_valid;
    logic                s2_take;
    logic [FP_WIDTH-1:0] rp_result;
    logic [2:0]          rp_flags;

    // S2 can load when empty or when its result leaves this cycle.
    assign s2_take   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_take;
    assign out_valid = s2_valid;

    // S1: capture the normalised operand on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid)
                s1_q <= fp_pkg::normalize(in_sign, in_exp, in_prod,
                                          in_is_nan, in_is_inf, in_is_zero);
        end
    end

    fp_round_pack u_round_pack (
        .s      (s1_q),
        .result (rp_result),
        .flags  (rp_flags)
    );

    // S2: register the packed result; held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s2_take) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= rp_result;
                out_flags  <= rp_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed-vector bench for fp_mul_norm_round.
module tb_fp_mul_norm_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic        in_is_nan, in_is_inf, in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [47:0] P_ONE   = 48'h4000_0000_0000;  // 1.0
    localparam logic [47:0] P_1P5   = 48'h6000_0000_0000;  // 1.5
    localparam logic [47:0] P_2P25  = 48'h9000_0000_0000;  // 2.25
    localparam logic [47:0] P_TOP   = 48'h8000_0000_0000;  // 2.0
    localparam logic [47:0] P_CARRY = {1'b0, 24'hFFFFFF, 1'b1, 22'h0};
    localparam logic [47:0] P_TIE   = {1'b0, 24'h800000, 1'b1, 22'h0};
    localparam logic [47:0] P_STKY  = {1'b0, 24'h800000, 1'b1, 22'h1};
    localparam logic [47:0] P_ODD   = {1'b0, 24'h800001, 1'b1, 22'h0};

    fp_mul_norm_round dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_prod    (in_prod),
        .in_is_nan  (in_is_nan),
        .in_is_inf  (in_is_inf),
        .in_is_zero (in_is_zero),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] p,
                         input logic nan, input logic inf, input logic zero);
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = e;
        in_prod    = p;
        in_is_nan  = nan;
        in_is_inf  = inf;
        in_is_zero = zero;
    endtask

    // Push one operand through an idle pipe and return what comes out.
    task automatic run_one(input logic s, input logic [9:0] e, input logic [47:0] p,
                           input logic nan, input logic inf, input logic zero,
                           output logic [31:0] r, output logic [2:0] f);
        int n;
        out_ready = 1'b1;
        drive(s, e, p, nan, inf, zero);
        #1;
        n = 0;
        while (!in_ready && n < 20) begin step(); n++; end
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin step(); n++; end
        if (!out_valid) begin
            vectors++; miscompares++;
            $display("FAIL run_one_timeout: out_valid never rose (exp=%h prod=%h)", e, p);
        end
        r = out_result;
        f = out_flags;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive(1'b0, 10'd0, 48'h0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        step(); step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++;
        if (out_result !== 32'h0 || out_flags !== 3'b000) begin
            miscompares++; $display("FAIL reset_outputs: got %h/%b want 00000000/000", out_result, out_flags);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    // Checks both the value and the exact two-cycle latency.
    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b0, 10'd127, P_2P25, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early: out_valid got %b want 0", out_valid); end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h40100000 || out_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_2p25: got v=%b %h/%b want v=1 40100000/000", out_valid, out_result, out_flags);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic [2:0] f;
        run_one(1'b0, 10'd127, P_CARRY, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h40000000 || f !== 3'b001) begin miscompares++; $display("FAIL round_carry: got %h/%b want 40000000/001", r, f); end
        run_one(1'b0, 10'd127, P_TIE, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h3F800000 || f !== 3'b001) begin miscompares++; $display("FAIL round_tie_even: got %h/%b want 3F800000/001", r, f); end
        run_one(1'b0, 10'd127, P_STKY, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h3F800001 || f !== 3'b001) begin miscompares++; $display("FAIL round_sticky: got %h/%b want 3F800001/001", r, f); end
        run_one(1'b0, 10'd127, P_ODD, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h3F800002 || f !== 3'b001) begin miscompares++; $display("FAIL round_tie_odd: got %h/%b want 3F800002/001", r, f); end
        run_one(1'b1, 10'd127, P_1P5, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'hBFC00000 || f !== 3'b000) begin miscompares++; $display("FAIL neg_1p5: got %h/%b want BFC00000/000", r, f); end
    endtask

    task automatic test_range();
        logic [31:0] r; logic [2:0] f;
        run_one(1'b0, 10'd254, P_TOP, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h7F800000 || f !== 3'b101) begin miscompares++; $display("FAIL overflow: got %h/%b want 7F800000/101", r, f); end
        run_one(1'b1, 10'd254, P_CARRY, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'hFF800000 || f !== 3'b101) begin miscompares++; $display("FAIL overflow_by_round: got %h/%b want FF800000/101", r, f); end
        run_one(1'b0, 10'd254, P_ONE, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h7F000000 || f !== 3'b000) begin miscompares++; $display("FAIL max_exp: got %h/%b want 7F000000/000", r, f); end
        run_one(1'b1, 10'd0, P_ONE, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h80000000 || f[2:1] !== 2'b01) begin miscompares++; $display("FAIL underflow: got %h/%b want 80000000/01x", r, f); end
        run_one(1'b0, 10'h3FB, P_1P5, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h00000000 || f[2:1] !== 2'b01) begin miscompares++; $display("FAIL underflow_neg_exp: got %h/%b want 00000000/01x", r, f); end
        run_one(1'b0, 10'd1, P_ONE, 1'b0, 1'b0, 1'b0, r, f);
        vectors++;
        if (r !== 32'h00800000 || f !== 3'b000) begin miscompares++; $display("FAIL min_normal: got %h/%b want 00800000/000", r, f); end
    endtask

    task automatic test_specials();
        logic [31:0] r; logic [2:0] f;
        run_one(1'b1, 10'd127, P_ONE, 1'b1, 1'b1, 1'b0, r, f);
        vectors++;
        if (r !== 32'h7FC00000 || f !== 3'b000) begin miscompares++; $display("FAIL nan_over_inf: got %h/%b want 7FC00000/000", r, f); end
        run_one(1'b1, 10'd127, P_ONE, 1'b0, 1'b1, 1'b1, r, f);
        vectors++;
        if (r !== 32'hFF800000 || f !== 3'b000) begin miscompares++; $display("FAIL inf_over_zero: got %h/%b want FF800000/000", r, f); end
        run_one(1'b1, 10'd254, P_TOP, 1'b0, 1'b0, 1'b1, r, f);
        vectors++;
        if (r !== 32'h80000000 || f !== 3'b000) begin miscompares++; $display("FAIL zero_special: got %h/%b want 80000000/000", r, f); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b0, 10'd127, P_2P25, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 10'd127, P_1P5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 10'd127, P_ONE, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h40100000) begin miscompares++; $display("FAIL b2b_first: got v=%b %h want v=1 40100000", out_valid, out_result); end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h3FC00000) begin miscompares++; $display("FAIL b2b_second: got v=%b %h want v=1 3FC00000", out_valid, out_result); end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F800000) begin miscompares++; $display("FAIL b2b_third: got v=%b %h want v=1 3F800000", out_valid, out_result); end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b0, 10'd127, P_2P25, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_a: in_ready got %b want 1", in_ready); end
        step();
        drive(1'b0, 10'd127, P_1P5, 1'b0, 1'b0, 1'b0);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_accept_b: in_ready got %b want 1", in_ready); end
        step();
        drive(1'b0, 10'd127, P_ONE, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 32'h40100000 || out_flags !== 3'b000) begin
                miscompares++;
                $display("FAIL bp_stall_%0d: got rdy=%b v=%b %h/%b want rdy=0 v=1 40100000/000",
                         i, in_ready, out_valid, out_result, out_flags);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h3FC00000) begin miscompares++; $display("FAIL bp_order_b: got v=%b %h want v=1 3FC00000", out_valid, out_result); end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'h3F800000) begin miscompares++; $display("FAIL bp_order_c: got v=%b %h want v=1 3F800000", out_valid, out_result); end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        int ghosts;
        out_ready = 1'b1;
        drive(1'b0, 10'd127, P_2P25, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 10'd127, P_1P5, 1'b0, 1'b0, 1'b0);
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 32'h0 || out_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL midflight_reset: got v=%b %h/%b want v=0 00000000/000", out_valid, out_result, out_flags);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midflight_in_ready: got %b want 1", in_ready); end
        ghosts = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) ghosts++;
        end
        vectors++;
        if (ghosts !== 0) begin miscompares++; $display("FAIL midflight_ghosts: got %0d results want 0", ghosts); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_range();
        test_specials();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
